serial_slave_mem: RTL and testbench
===================================

Name: serial_slave_mem

Overview:
Parametrised successor to the 2K serial bus slave. It is a memory-mapped target on the serial master/slave bus, with a generic address width, data width, memory depth and acknowledge length. It adds address-range checking with NACK, abort on AD_SEL drop, and an optional parity check. It sits behind the bus arbiter and receives address and write data on B_BUS_OUT. It returns read data on B_BUS_IN.

Parameters:
ADDR_WIDTH, 16, serial address bits received per transaction (LSB first)
DATA_WIDTH, 8, bits per memory word and per data phase (LSB first)
MEM_DEPTH, 2048, number of words; valid addresses are 0..MEM_DEPTH-1
ACK_CYCLES, 2, length in cycles of each acknowledge phase (>=1)

Ports:
CLK  in  1  bus clock; all logic on the rising edge
RSTN  in  1  asynchronous active-low reset
AD_SEL  in  1  slave select from the arbiter; must stay high for the whole address phase
B_RW  in  1  transfer direction, 1=write, 0=read; sampled in the last address-bit cycle
B_BUS_OUT  in  1  serial master-to-slave line (address bits, write data)
B_BUS_IN  out  1  serial slave-to-master line (read data)
B_ACK  out  1  acknowledge, high during ACK phases when the transfer is accepted
B_SBSY  out  1  slave busy
S_DVALID  out  1  one-cycle pulse when a write commits
S_DOUT  out  DATA_WIDTH  last committed write data

Behaviour:
- Reset, asynchronous: all outputs 0, FSM in IDLE, counters and shift registers 0. Memory contents are not reset and are undefined until written.
- FSM states: IDLE, ADDR, ADDR_ACK, WRITE, WR_ACK, READ. B_SBSY = (state != IDLE), decoded from the state register.
- One bit counter is shared by all phases. It clears on every state change.
- IDLE: AD_SEL=1 -> ADDR on the next cycle.
- ADDR: ADDR_WIDTH cycles. In cycle i, capture B_BUS_OUT into address bit i. In cycle ADDR_WIDTH-1, capture B_RW. If AD_SEL=0 in any ADDR cycle: abort to IDLE, no ACK, no memory access.
- ADDR_ACK: ACK_CYCLES cycles.
  - addr < MEM_DEPTH: B_ACK=1 every cycle, then go to WRITE (rw=1) or READ (rw=0). On entry to READ, the mem[addr] word is loaded into the read shift register.
  - addr out of range: B_ACK=0 (NACK), B_SBSY stays 1, then go to IDLE.
- WRITE: DATA_WIDTH cycles; capture bit i in cycle i. After the last bit, write mem[addr].
- WR_ACK: ACK_CYCLES cycles with B_ACK=1. In the final WR_ACK cycle, S_DVALID=1 and S_DOUT = written word. S_DOUT then holds its value until the next commit. Next state is IDLE.
- READ: DATA_WIDTH cycles; B_BUS_IN = word bit i in cycle i. B_BUS_IN=0 in every other state. Next state is IDLE.
- B_ACK=0 in all states except ADDR_ACK (in range) and WR_ACK.
- AD_SEL is ignored after ADDR.
- Back-to-back transactions: after a transaction returns to IDLE, AD_SEL=1 starts a new transaction on the following cycle. Minimum one IDLE cycle between transactions.
- Address bits above clog2(MEM_DEPTH) only take part in the range check. Memory index = addr[clog2(MEM_DEPTH)-1:0].
- Read-after-write to the same address returns the new data, because the write commits before WR_ACK.
- RSTN asserted mid-transaction: immediate return to IDLE with outputs 0. A write that has not yet reached the commit point is discarded.

Optional Feature:
Macro: SERIAL_SLAVE_PARITY_EN.
- Defined:
  - WRITE is extended by one cycle to capture an even-parity bit.
  - If the parity mismatches, the memory write is suppressed, WR_ACK drives B_ACK=0 for ACK_CYCLES cycles, and there is no S_DVALID pulse.
  - READ is extended by one cycle that drives the even-parity bit of the word.
- Undefined: no parity cycles, and behaviour is exactly as in Behaviour above.

Test Plan:
- Write at defaults: addr 0x0005, rw=1, data 0xA5 -> B_ACK high for 2 cycles after address; B_ACK high for 2 cycles after data; S_DVALID pulses once with S_DOUT=0xA5.
- Read back at defaults: addr 0x0005, rw=0 -> B_BUS_IN serial 1,0,1,0,0,1,0,1 (LSB first) over 8 cycles; B_SBSY falls the cycle after.
- Out of range: addr 0x0800 (MEM_DEPTH=2048) -> B_ACK stays 0 for the 2 ACK cycles; FSM returns to IDLE; a read of addr 0x0000 still returns its prior value.
- Abort: AD_SEL dropped at address bit 7 -> IDLE on the next cycle; no ACK, no S_DVALID; memory unchanged.
- Reset mid-write: RSTN low after data bit 3 -> all outputs 0 immediately; a later read of that address returns the old value.
- Parametric: DATA_WIDTH=16, MEM_DEPTH=64, ACK_CYCLES=3; write 0xBEEF to addr 63 then read it -> 3-cycle ACKs, read data 0xBEEF; with SERIAL_SLAVE_PARITY_EN, a corrupted parity bit -> NACK and no write.

Source files
------------

// File: rtl/serial_slave_mem.sv
// serial_slave_mem: serial-bus memory slave with range-check NACK and AD_SEL abort.
// Define SERIAL_SLAVE_PARITY_EN to add an even-parity bit to every write and read data phase.
module serial_slave_mem #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 2048,
  parameter int ACK_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  AD_SEL,
  input  logic                  B_RW,
  input  logic                  B_BUS_OUT,
  output logic                  B_BUS_IN,
  output logic                  B_ACK,
  output logic                  B_SBSY,
  output logic                  S_DVALID,
  output logic [DATA_WIDTH-1:0] S_DOUT
);
`ifdef SERIAL_SLAVE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int IW  = $clog2(MEM_DEPTH);
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam int XN  = (ADDR_WIDTH > DATA_WIDTH + PAR) ? ADDR_WIDTH : DATA_WIDTH + PAR;
  localparam int MX  = (XN > ACK_CYCLES) ? XN : ACK_CYCLES;
  localparam int CW  = $clog2(MX + 1);
  localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] K_LAST = CW'(ACK_CYCLES - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH + PAR - 1);
  localparam logic [CW-1:0] D_N    = CW'(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH = AW1'(MEM_DEPTH);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WRITE, WR_ACK, READ} state_t;

  state_t                st, nxt;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata, rdata, wd_next;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  dir, wr_ok, par_ok, commit, in_range;
  logic [IW-1:0]         idx;

`ifdef SERIAL_SLAVE_PARITY_EN
  assign wd_next = wdata;
  assign par_ok  = (^wdata) == B_BUS_OUT;
`else
  assign wd_next = {B_BUS_OUT, wdata[DATA_WIDTH-1:1]};
  assign par_ok  = 1'b1;
`endif

  assign in_range = {1'b0, addr} < DEPTH;
  assign idx      = addr[IW-1:0];
  assign commit   = st == WRITE && cnt == D_LAST && par_ok;

  always_comb begin
    nxt      = st;
    B_SBSY   = st != IDLE;
    B_ACK    = (st == ADDR_ACK && in_range) || (st == WR_ACK && wr_ok);
    S_DVALID = st == WR_ACK && cnt == K_LAST && wr_ok;
    B_BUS_IN = st == READ && ((cnt < D_N) ? rdata[0] : ^rdata);
    case (st)
      IDLE:     nxt = AD_SEL ? ADDR : IDLE;
      ADDR:     nxt = !AD_SEL ? IDLE : (cnt == A_LAST) ? ADDR_ACK : ADDR;
      ADDR_ACK: nxt = (cnt != K_LAST) ? ADDR_ACK : !in_range ? IDLE : dir ? WRITE : READ;
      WRITE:    nxt = (cnt == D_LAST) ? WR_ACK : WRITE;
      WR_ACK:   nxt = (cnt == K_LAST) ? IDLE : WR_ACK;
      READ:     nxt = (cnt == D_LAST) ? IDLE : READ;
      default:  nxt = IDLE;
    endcase
  end

  // rdata rotates rather than shifts so the parity of the full word is still available after the data bits
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      st     <= IDLE;
      cnt    <= '0;
      addr   <= '0;
      wdata  <= '0;
      rdata  <= '0;
      dir    <= 1'b0;
      wr_ok  <= 1'b0;
      S_DOUT <= '0;
    end else begin
      st  <= nxt;
      cnt <= (nxt != st || st == IDLE) ? '0 : cnt + 1'b1;
      if (st == ADDR) addr <= {B_BUS_OUT, addr[ADDR_WIDTH-1:1]};
      if (st == ADDR && cnt == A_LAST) dir <= B_RW;
      if (st == WRITE && cnt < D_N) wdata <= {B_BUS_OUT, wdata[DATA_WIDTH-1:1]};
      if (st == WRITE && cnt == D_LAST) wr_ok <= par_ok;
      if (commit) S_DOUT <= wd_next;
      if (st == ADDR_ACK && nxt == READ) rdata <= mem[idx];
      else if (st == READ) rdata <= {rdata[0], rdata[DATA_WIDTH-1:1]};
    end

  always_ff @(posedge CLK)
    if (commit) mem[idx] <= wd_next;
endmodule

// File: tb/tb_serial_slave_mem.sv
// tb_serial_slave_mem: randomized bench for serial_slave_mem, default and 16-bit/64-word/3-cycle-ACK instances,
// checked against a word-level associative-array memory model.
module tb_serial_slave_mem;
`ifdef SERIAL_SLAVE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  logic        CLK = 1'b0, RSTN = 1'b0;
  logic [1:0]  ad_sel = '0, rw = '0, bo = '0;
  logic [1:0]  bin, ack, sbsy, dv;
  logic [7:0]  dout0;
  logic [15:0] dout1;
  logic [15:0] m0 [int];
  logic [15:0] m1 [int];
  logic [15:0] last [2];
  int          wq0 [$];
  int          wq1 [$];
  int          errors = 0, checks = 0;

  always #5 CLK = ~CLK;

  serial_slave_mem u0 (
    .CLK(CLK), .RSTN(RSTN), .AD_SEL(ad_sel[0]), .B_RW(rw[0]), .B_BUS_OUT(bo[0]),
    .B_BUS_IN(bin[0]), .B_ACK(ack[0]), .B_SBSY(sbsy[0]), .S_DVALID(dv[0]), .S_DOUT(dout0)
  );

  serial_slave_mem #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_DEPTH(64), .ACK_CYCLES(3)) u1 (
    .CLK(CLK), .RSTN(RSTN), .AD_SEL(ad_sel[1]), .B_RW(rw[1]), .B_BUS_OUT(bo[1]),
    .B_BUS_IN(bin[1]), .B_ACK(ack[1]), .B_SBSY(sbsy[1]), .S_DVALID(dv[1]), .S_DOUT(dout1)
  );

  function automatic logic [15:0] dout_of(input int s);
    return s != 0 ? dout1 : {8'h00, dout0};
  endfunction

  function automatic int depth(input int s);
    return s != 0 ? 64 : 2048;
  endfunction

  // Drives one whole transaction from an IDLE negedge and records what the slave did in each phase.
  task automatic run_xact(input int s, input logic [15:0] a, input bit w, input logic [15:0] d,
                          input int abort_at, input bit bad, input int stop_at,
                          output int na, output int nw, output int ndv, output logic [16:0] rd,
                          output int stray, output bit be);
    int dn, k;
    dn = s != 0 ? 16 : 8;
    k  = s != 0 ? 3 : 2;
    na = 0; nw = 0; ndv = 0; rd = '0; stray = 0; be = 1'b0;
    ad_sel[s] = 1'b1;
    rw[s] = w;
    if ((ack[s] | bin[s] | dv[s] | sbsy[s]) !== 1'b0) stray++;
    @(negedge CLK);
    for (int i = 0; i < 16; i++) begin
      ad_sel[s] = (i != abort_at);
      bo[s] = a[i];
      if ((ack[s] | bin[s] | dv[s] | !sbsy[s]) !== 1'b0) stray++;
      @(negedge CLK);
      if (i == abort_at) begin
        if ((ack[s] | dv[s]) !== 1'b0) stray++;
        be = sbsy[s];
        return;
      end
    end
    ad_sel[s] = 1'b0;
    for (int i = 0; i < k; i++) begin
      if (ack[s] === 1'b1) na++;
      if ((bin[s] | dv[s] | !sbsy[s]) !== 1'b0) stray++;
      @(negedge CLK);
    end
    if (int'(a) < depth(s)) begin
      if (w) begin
        for (int i = 0; i < dn + PAR; i++) begin
          if (i == stop_at) return;
          bo[s] = (i < dn) ? d[i] : ((^d) ^ bad);
          if ((ack[s] | bin[s] | dv[s] | !sbsy[s]) !== 1'b0) stray++;
          @(negedge CLK);
        end
        for (int i = 0; i < k; i++) begin
          if (ack[s] === 1'b1) nw++;
          if (dv[s] === 1'b1) ndv++;
          if ((bin[s] | !sbsy[s]) !== 1'b0) stray++;
          @(negedge CLK);
        end
      end else begin
        for (int i = 0; i < dn + PAR; i++) begin
          rd[i] = bin[s];
          if ((ack[s] | dv[s] | !sbsy[s]) !== 1'b0) stray++;
          @(negedge CLK);
        end
      end
    end
    be = sbsy[s];
  endtask

  task automatic do_write(input int s, input logic [15:0] a, input logic [15:0] d, input bit bad, input string nm);
    int na, nw, ndv, stray, k;
    logic [16:0] rd;
    bit be, inr, ok;
    k = s != 0 ? 3 : 2;
    inr = int'(a) < depth(s);
    ok = inr && !(bad && PAR == 1);
    run_xact(s, a, 1'b1, d, -1, bad, -1, na, nw, ndv, rd, stray, be);
    checks++;
    if (na != (inr ? k : 0)) begin errors++; $display("FAIL %s addr_ack cycles: got %0d want %0d", nm, na, inr ? k : 0); end
    checks++;
    if (nw != (ok ? k : 0)) begin errors++; $display("FAIL %s wr_ack cycles: got %0d want %0d", nm, nw, ok ? k : 0); end
    checks++;
    if (ndv != (ok ? 1 : 0)) begin errors++; $display("FAIL %s dvalid pulses: got %0d want %0d", nm, ndv, ok ? 1 : 0); end
    checks++;
    if (stray != 0 || be !== 1'b0) begin errors++; $display("FAIL %s protocol: stray=%0d busy_after=%0b want 0/0", nm, stray, be); end
    if (ok) begin
      if (s != 0) begin m1[int'(a)] = d; wq1.push_back(int'(a)); end
      else begin m0[int'(a)] = d; wq0.push_back(int'(a)); end
      last[s] = d;
    end
    checks++;
    if (dout_of(s) !== last[s]) begin errors++; $display("FAIL %s S_DOUT: got %h want %h", nm, dout_of(s), last[s]); end
  endtask

  task automatic do_read(input int s, input logic [15:0] a, input string nm);
    int na, nw, ndv, stray, k, dn;
    logic [16:0] rd;
    logic [15:0] exp, got;
    bit be, inr;
    k = s != 0 ? 3 : 2;
    dn = s != 0 ? 16 : 8;
    inr = int'(a) < depth(s);
    run_xact(s, a, 1'b0, 16'h0, -1, 1'b0, -1, na, nw, ndv, rd, stray, be);
    checks++;
    if (na != (inr ? k : 0)) begin errors++; $display("FAIL %s addr_ack cycles: got %0d want %0d", nm, na, inr ? k : 0); end
    checks++;
    if (stray != 0 || be !== 1'b0) begin errors++; $display("FAIL %s protocol: stray=%0d busy_after=%0b want 0/0", nm, stray, be); end
    if (inr) begin
      exp = s != 0 ? m1[int'(a)] : m0[int'(a)];
      got = s != 0 ? rd[15:0] : {8'h00, rd[7:0]};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL %s read data: got %h want %h", nm, got, exp); end
`ifdef SERIAL_SLAVE_PARITY_EN
      checks++;
      if (rd[dn] !== ^exp) begin errors++; $display("FAIL %s read parity: got %b want %b", nm, rd[dn], ^exp); end
`endif
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    repeat (2) @(negedge CLK);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ({sbsy[s], ack[s], dv[s], bin[s]} !== 4'b0) begin
        errors++; $display("FAIL reset outputs inst%0d: got %b want 0000", s, {sbsy[s], ack[s], dv[s], bin[s]});
      end
    end
    checks++;
    if ({dout1, dout0} !== 24'h0) begin errors++; $display("FAIL reset S_DOUT: got %h want 0", {dout1, dout0}); end
    RSTN = 1'b1;
    last[0] = '0;
    last[1] = '0;
    @(negedge CLK);
    checks++;
    if (sbsy !== 2'b00) begin errors++; $display("FAIL idle after reset: busy=%b want 00", sbsy); end
  endtask

  task automatic test_write_read();
    do_write(0, 16'h0005, 16'h00A5, 1'b0, "wr_0005");
    do_read(0, 16'h0005, "rd_0005");
    do_write(0, 16'h07FF, 16'h003C, 1'b0, "wr_07ff");
    do_read(0, 16'h07FF, "rd_07ff");
  endtask

  task automatic test_out_of_range();
    do_write(0, 16'h0000, 16'h005A, 1'b0, "wr_0000");
    do_write(0, 16'h0800, 16'h00C3, 1'b0, "oor_wr_0800");
    do_read(0, 16'h0800, "oor_rd_0800");
    do_write(0, 16'hFFFF, 16'h0011, 1'b0, "oor_wr_ffff");
    do_read(0, 16'h0000, "rd_0000_after_oor");
  endtask

  task automatic test_abort();
    int na, nw, ndv, stray;
    logic [16:0] rd;
    bit be;
    do_write(0, 16'h0123, 16'h0077, 1'b0, "wr_0123");
    run_xact(0, 16'h0123, 1'b1, 16'h0088, 7, 1'b0, -1, na, nw, ndv, rd, stray, be);
    checks++;
    if (stray != 0 || be !== 1'b0) begin errors++; $display("FAIL abort: stray=%0d busy_after=%0b want 0/0", stray, be); end
    @(negedge CLK);
    checks++;
    if ({sbsy[0], ack[0], dv[0]} !== 3'b0) begin errors++; $display("FAIL abort idle: got %b want 000", {sbsy[0], ack[0], dv[0]}); end
    checks++;
    if (dout0 !== last[0][7:0]) begin errors++; $display("FAIL abort S_DOUT: got %h want %h", dout0, last[0][7:0]); end
    do_read(0, 16'h0123, "rd_0123_after_abort");
  endtask

  task automatic test_reset_mid_write();
    int na, nw, ndv, stray;
    logic [16:0] rd;
    bit be;
    do_write(0, 16'h0042, 16'h0096, 1'b0, "wr_0042");
    run_xact(0, 16'h0042, 1'b1, 16'h0069, -1, 1'b0, 4, na, nw, ndv, rd, stray, be);
    RSTN = 1'b0;
    #1;
    checks++;
    if ({sbsy[0], ack[0], dv[0], bin[0]} !== 4'b0) begin
      errors++; $display("FAIL mid-write reset outputs: got %b want 0000", {sbsy[0], ack[0], dv[0], bin[0]});
    end
    checks++;
    if (dout0 !== 8'h00) begin errors++; $display("FAIL mid-write reset S_DOUT: got %h want 00", dout0); end
    ad_sel = '0;
    last[0] = '0;
    last[1] = '0;
    @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    do_read(0, 16'h0042, "rd_0042_after_reset");
  endtask

  task automatic test_param();
    do_write(1, 16'd63, 16'hBEEF, 1'b0, "p_wr_63");
    do_read(1, 16'd63, "p_rd_63");
    do_write(1, 16'd64, 16'h1234, 1'b0, "p_oor_wr_64");
    do_read(1, 16'd63, "p_rd_63_after_oor");
`ifdef SERIAL_SLAVE_PARITY_EN
    do_write(1, 16'd63, 16'h1234, 1'b1, "p_badpar_63");
    do_read(1, 16'd63, "p_rd_63_after_badpar");
    do_write(0, 16'h0005, 16'h00F0, 1'b1, "badpar_0005");
    do_read(0, 16'h0005, "rd_0005_after_badpar");
`endif
  endtask

  task automatic test_back_to_back();
    int s;
    logic [15:0] a, d;
    for (int n = 0; n < 40; n++) begin
      s = int'($urandom_range(0, 1));
      d = 16'($urandom) & (s != 0 ? 16'hFFFF : 16'h00FF);
      if ($urandom_range(0, 9) == 0) a = 16'(depth(s) + int'($urandom_range(0, 200)));
      else if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(0, depth(s) - 1));
      else if (s != 0) a = 16'(wq1[$urandom_range(0, wq1.size() - 1)]);
      else a = 16'(wq0[$urandom_range(0, wq0.size() - 1)]);
      if ($urandom_range(0, 1) == 0 || int'(a) >= depth(s)) do_write(s, a, d, 1'b0, "b2b_wr");
      else begin
        if ((s != 0 && !m1.exists(int'(a))) || (s == 0 && !m0.exists(int'(a)))) do_write(s, a, d, 1'b0, "b2b_wr");
        do_read(s, a, "b2b_rd");
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_abort();
    test_reset_mid_write();
    test_param();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
